// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 encodings,
// byte-lane masks and the legality check applied to a registered memory op.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] MASK_BYTE     = 4'b0001;
    localparam logic [3:0] MASK_HALFWORD = 4'b0011;
    localparam logic [3:0] MASK_FULLWORD = 4'b1111;

    // funct3[1:0] carries the access size for both loads and stores.
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            2'b00:   lane_mask = MASK_BYTE;
            2'b01:   lane_mask = MASK_HALFWORD;
            2'b10:   lane_mask = MASK_FULLWORD;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic op_illegal(input logic       store,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
        logic bad_f3;
        logic misaligned;
        if (store)
            bad_f3 = !((f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW));
        else
            bad_f3 = !((f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                       (f3 == F3_LBU) || (f3 == F3_LHU));
        misaligned = ((f3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
        op_illegal = bad_f3 || misaligned;
    endfunction

endpackage

// File: rtl/load_store_unit_load_ext.sv
// Load data extension: picks the low byte/halfword/word of the raw RAM word
// and sign- or zero-extends it according to funct3.
module lsu_load_ext
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] raw_i,
    output logic [XLEN-1:0] ext_o
);

    always_comb begin
        ext_o = raw_i;
        case (funct3_i)
            F3_LB:   ext_o = {{(XLEN-8){raw_i[7]}}, raw_i[7:0]};
            F3_LBU:  ext_o = {{(XLEN-8){1'b0}}, raw_i[7:0]};
            F3_LH:   ext_o = {{(XLEN-16){raw_i[15]}}, raw_i[15:0]};
            F3_LHU:  ext_o = {{(XLEN-16){1'b0}}, raw_i[15:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op, drives the RAM port for a single
// ACCESS cycle, then holds a completion record until writeback takes it.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_base,
    input  logic [11:0]     req_imm,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [RD_W-1:0] req_rd,
    output logic [XLEN-1:0] ram_addr,
    output logic [XLEN-1:0] ram_wdat,
    output logic            ram_we,
    output logic            ram_re,
    output logic [3:0]      ram_type,
    output logic            sign,
    input  logic [XLEN-1:0] ram_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_store,
    output logic            wb_err
);

    lsu_state_e      state_q, state_d;
    logic            store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [RD_W-1:0] rd_q;
    logic [XLEN-1:0] wb_data_q;

    logic            accept;
    logic            err;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] ext_data;

    assign accept  = req_valid && (state_q == ST_IDLE);
    assign imm_ext = {{(XLEN-12){req_imm[11]}}, req_imm};
    assign err     = op_illegal(store_q, funct3_q, addr_q[1:0]);

    lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
        .funct3_i (funct3_q),
        .raw_i    (ram_rdata),
        .ext_o    (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            store_q   <= 1'b0;
            funct3_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                addr_q   <= req_base + imm_ext;
                wdata_q  <= req_wdata;
                rd_q     <= req_rd;
            end
            // Stores and erroring ops report zero data, so only legal loads latch RAM data.
            if (state_q == ST_ACCESS)
                wb_data_q <= (!store_q && !err) ? ext_data : '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        ram_addr  = '0;
        ram_wdat  = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_type  = 4'b0000;
        sign      = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        wb_store  = 1'b0;
        wb_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                ram_addr = addr_q;
                ram_type = lane_mask(funct3_q[1:0]);
                if (!err) begin
                    if (store_q) begin
                        ram_we   = 1'b1;
                        ram_wdat = wdata_q;
                    end else begin
                        ram_re = 1'b1;
                        sign   = ~funct3_q[2];
                    end
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                wb_valid = 1'b1;
                wb_rd    = rd_q;
                wb_data  = wb_data_q;
                wb_store = store_q;
                wb_err   = err;
                if (wb_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
